io_bus_arbiter: RTL and testbench

Round-robin arbiter sharing the single registered I/O master port (classic Wishbone-style cyc/stb/ack, plus stall) among NREQ requesters, such as the CPU slave path and the copper master. It sits between the requesters and the I/O device fabric. It registers every master-side output, holds the grant through read-modify-write cycles, and terminates hung accesses with a bus error.

---
 rtl/io_arb_pkg.sv | 15 +
 rtl/io_bus_arbiter_if.sv | 46 ++++
 rtl/io_arb_rr_pick.sv | 39 +++
 rtl/io_bus_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared types and bus widths for the I/O bus arbiter.
package io_arb_pkg;

   localparam int IOARB_AW = 32;
   localparam int IOARB_DW = 32;
   localparam int IOARB_SW = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ACK  = 2'd1,
      WAIT_NACK = 2'd2,
      LOCK      = 2'd3
   } io_arb_state_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if: requester-side and master-side bus signals of the
// I/O bus arbiter. The master modport is the arbiter's view, the slave
// modport is the view of the surrounding requesters and device fabric.
interface io_bus_arbiter_if #(
   parameter int NREQ = 3
);
   localparam int AW = io_arb_pkg::IOARB_AW;
   localparam int DW = io_arb_pkg::IOARB_DW;
   localparam int SW = io_arb_pkg::IOARB_SW;

   logic                 io_gate_en_i;
   logic [NREQ-1:0]      req_cyc_i;
   logic [NREQ-1:0]      req_stb_i;
   logic [NREQ-1:0]      req_we_i;
   logic [SW*NREQ-1:0]   req_sel_i;
   logic [AW*NREQ-1:0]   req_adr_i;
   logic [DW*NREQ-1:0]   req_dat_i;
   logic [NREQ-1:0]      req_ack_o;
   logic [NREQ-1:0]      req_err_o;
   logic [DW-1:0]        req_dat_o;
   logic [NREQ-1:0]      gnt_o;
   logic                 m_cyc_o;
   logic                 m_stb_o;
   logic                 m_we_o;
   logic [SW-1:0]        m_sel_o;
   logic [AW-1:0]        m_adr_o;
   logic [DW-1:0]        m_dat_o;
   logic                 m_ack_i;
   logic                 m_stall_i;
   logic [DW-1:0]        m_dat_i;

   modport master (
      input  io_gate_en_i, req_cyc_i, req_stb_i, req_we_i, req_sel_i,
             req_adr_i, req_dat_i, m_ack_i, m_stall_i, m_dat_i,
      output req_ack_o, req_err_o, req_dat_o, gnt_o, m_cyc_o, m_stb_o,
             m_we_o, m_sel_o, m_adr_o, m_dat_o
   );

   modport slave (
      output io_gate_en_i, req_cyc_i, req_stb_i, req_we_i, req_sel_i,
             req_adr_i, req_dat_i, m_ack_i, m_stall_i, m_dat_i,
      input  req_ack_o, req_err_o, req_dat_o, gnt_o, m_cyc_o, m_stb_o,
             m_we_o, m_sel_o, m_adr_o, m_dat_o
   );

endinterface

// File: rtl/io_arb_rr_pick.sv
// io_arb_rr_pick: combinational round-robin picker. Searches the eligible
// vector starting at i_ptr+1 (mod NREQ) and returns the first hit as a
// one-hot grant plus its binary index.
module io_arb_rr_pick #(
   parameter int NREQ = 3,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_elig,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [PW-1:0]   o_idx,
   output logic            o_valid
);

   // Walk from the farthest candidate to the nearest so the nearest hit wins
   always_comb begin : p_pick
      int            w_j;
      logic [PW-1:0] w_jx;
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_j     = 0;
      w_jx    = '0;
      for (int k = NREQ; k >= 1; k--) begin
         w_j = int'(i_ptr) + k;
         if (w_j >= NREQ) begin
            w_j = w_j - NREQ;
         end
         w_jx = PW'(w_j);
         if (i_elig[w_jx]) begin
            o_gnt       = '0;
            o_gnt[w_jx] = 1'b1;
            o_idx       = w_jx;
            o_valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter sharing one registered Wishbone-style
// I/O master port among NREQ requesters. All master-side outputs are
// registered, the grant is held across read-modify-write sequences (LOCK),
// and an aborted requester releases the bus at once.
// Optional feature macro: IOARB_TIMEOUT_EN -- terminates an unacknowledged
// access after TO_CYCLES WAIT_ACK cycles with a one-cycle req_err_o pulse.
module io_bus_arbiter
   import io_arb_pkg::*;
#(
   parameter int NREQ      = 3,
   parameter int TO_CYCLES = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   io_bus_arbiter_if.master bus
);

   localparam int PW = $clog2(NREQ);

   localparam logic [1:0] S_IDLE      = IDLE;
   localparam logic [1:0] S_WAIT_ACK  = WAIT_ACK;
   localparam logic [1:0] S_WAIT_NACK = WAIT_NACK;
   localparam logic [1:0] S_LOCK      = LOCK;

   // Reject unsupported configurations at elaboration
   if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
      $error("io_bus_arbiter: NREQ must be 2..4");
   end
   if (TO_CYCLES < 1 || TO_CYCLES > 255) begin : g_bad_to
      $error("io_bus_arbiter: TO_CYCLES must be 1..255");
   end

   logic [1:0]          r_state;
   logic [PW-1:0]       r_ptr;
   logic [PW-1:0]       r_gidx;
   logic [NREQ-1:0]     r_gnt;
   logic [NREQ-1:0]     r_ack;
   logic [IOARB_DW-1:0] r_rdat;
   logic                r_cyc;
   logic                r_stb;
   logic                r_we;
   logic [IOARB_SW-1:0] r_sel;
   logic [IOARB_AW-1:0] r_adr;
   logic [IOARB_DW-1:0] r_wdat;

   logic [NREQ-1:0]     w_elig;
   logic [NREQ-1:0]     w_pick_gnt;
   logic [PW-1:0]       w_pick_idx;
   logic                w_pick_vld;
   logic                w_issue_ok;
   logic                w_g_cyc;
   logic                w_g_stb;
   logic                w_to_fire;
   logic [PW-1:0]       w_src_idx;
   logic [IOARB_SW-1:0] w_sel [NREQ];
   logic [IOARB_AW-1:0] w_adr [NREQ];
   logic [IOARB_DW-1:0] w_dat [NREQ];

   // Per-requester eligibility and unpacked field slices
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_elig[gi] = bus.req_cyc_i[gi] & bus.req_stb_i[gi];
      assign w_sel[gi]  = bus.req_sel_i[gi*IOARB_SW +: IOARB_SW];
      assign w_adr[gi]  = bus.req_adr_i[gi*IOARB_AW +: IOARB_AW];
      assign w_dat[gi]  = bus.req_dat_i[gi*IOARB_DW +: IOARB_DW];
   end

   io_arb_rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .i_elig  (w_elig),
      .i_ptr   (r_ptr),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_vld)
   );

   // A new arbitrated grant needs the gate open and a quiet device
   assign w_issue_ok = bus.io_gate_en_i & ~bus.m_stall_i & ~bus.m_ack_i;
   assign w_g_cyc    = bus.req_cyc_i[r_gidx];
   assign w_g_stb    = bus.req_stb_i[r_gidx];
   // In IDLE the cycle fields come from the winner, otherwise from the holder
   assign w_src_idx  = (r_state == S_IDLE) ? w_pick_idx : r_gidx;

`ifdef IOARB_TIMEOUT_EN
   logic [7:0]      r_to_cnt;
   logic [NREQ-1:0] r_err;

   assign w_to_fire = (r_state == S_WAIT_ACK) && !bus.m_ack_i && w_g_cyc &&
                      (r_to_cnt == 8'(TO_CYCLES - 1));

   // Count WAIT_ACK cycles from zero and pulse the error for one cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_to_cnt <= '0;
         r_err    <= '0;
      end else begin
         r_err <= w_to_fire ? r_gnt : '0;
         if (r_state != S_WAIT_ACK) begin
            r_to_cnt <= '0;
         end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
         end
      end
   end

   assign bus.req_err_o = r_err;
`else
   assign w_to_fire     = 1'b0;
   assign bus.req_err_o = '0;
`endif

   // Main arbitration state machine with registered master outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_ptr   <= PW'(NREQ - 1);
         r_gidx  <= '0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_rdat  <= '0;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
         r_we    <= 1'b0;
         r_sel   <= '0;
         r_adr   <= '0;
         r_wdat  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pick_vld && w_issue_ok) begin
                  r_gnt   <= w_pick_gnt;
                  r_gidx  <= w_pick_idx;
                  r_cyc   <= 1'b1;
                  r_stb   <= 1'b1;
                  r_we    <= bus.req_we_i[w_src_idx];
                  r_sel   <= w_sel[w_src_idx];
                  r_adr   <= w_adr[w_src_idx];
                  r_wdat  <= w_dat[w_src_idx];
                  r_state <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (bus.m_ack_i) begin
                  r_rdat  <= bus.m_dat_i;
                  r_ack   <= r_gnt;
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_we    <= 1'b0;
                  r_sel   <= '0;
                  r_adr   <= '0;
                  r_wdat  <= '0;
                  r_ptr   <= r_gidx;
                  r_state <= S_WAIT_NACK;
               end else if (!w_g_cyc || w_to_fire) begin
                  // Abort or timeout: release the bus without an ack
                  r_gnt   <= '0;
                  r_rdat  <= '0;
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_we    <= 1'b0;
                  r_sel   <= '0;
                  r_adr   <= '0;
                  r_wdat  <= '0;
                  r_ptr   <= r_gidx;
                  r_state <= S_IDLE;
               end
            end
            S_WAIT_NACK: begin
               if (!w_g_stb) begin
                  r_ack <= '0;
                  if (w_g_cyc) begin
                     r_state <= S_LOCK;
                  end else begin
                     r_gnt   <= '0;
                     r_rdat  <= '0;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_LOCK: begin
               if (!w_g_cyc) begin
                  r_gnt   <= '0;
                  r_rdat  <= '0;
                  r_state <= S_IDLE;
               end else if (w_g_stb && !bus.m_stall_i) begin
                  // Locked re-issue: same holder, no arbitration, gate ignored
                  r_cyc   <= 1'b1;
                  r_stb   <= 1'b1;
                  r_we    <= bus.req_we_i[w_src_idx];
                  r_sel   <= w_sel[w_src_idx];
                  r_adr   <= w_adr[w_src_idx];
                  r_wdat  <= w_dat[w_src_idx];
                  r_state <= S_WAIT_ACK;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ack_o = r_ack;
   assign bus.req_dat_o = r_rdat;
   assign bus.gnt_o     = r_gnt;
   assign bus.m_cyc_o   = r_cyc;
   assign bus.m_stb_o   = r_stb;
   assign bus.m_we_o    = r_we;
   assign bus.m_sel_o   = r_sel;
   assign bus.m_adr_o   = r_adr;
   assign bus.m_dat_o   = r_wdat;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed, table-driven bench for io_bus_arbiter with
// hand-written sequences for contention, RMW lock, timeout and async reset.
// Build with IOARB_TIMEOUT_EN defined to also exercise the timeout path.
module tb_io_bus_arbiter;

   localparam int NREQ = 3;
`ifdef IOARB_TIMEOUT_EN
   localparam int TO_CYC = 8;
`else
   localparam int TO_CYC = 255;
`endif

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   always #5 clk_i = ~clk_i;

   io_bus_arbiter_if #(.NREQ(NREQ)) bus ();

   io_bus_arbiter #(
      .NREQ      (NREQ),
      .TO_CYCLES (TO_CYC)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [2:0]  cyc, stb, we;
      logic        gate, stall, mack;
      logic [31:0] mdat;
      logic [2:0]  e_gnt;
      logic        e_mcyc, e_we;
      logic [2:0]  e_ack;
      logic [31:0] e_adr, e_rdat;
   } vec_t;

   vec_t vecs [25];

   function automatic vec_t mk(input logic [2:0] cyc, input logic [2:0] stb,
                               input logic [2:0] we, input logic gate,
                               input logic stall, input logic mack,
                               input logic [31:0] mdat, input logic [2:0] eg,
                               input logic emc, input logic ewe,
                               input logic [2:0] ea, input logic [31:0] eadr,
                               input logic [31:0] erd);
      vec_t v;
      v.cyc = cyc; v.stb = stb; v.we = we; v.gate = gate; v.stall = stall;
      v.mack = mack; v.mdat = mdat; v.e_gnt = eg; v.e_mcyc = emc;
      v.e_we = ewe; v.e_ack = ea; v.e_adr = eadr; v.e_rdat = erd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [2:0] cyc, input logic [2:0] stb,
                        input logic [2:0] we, input logic mack,
                        input logic [31:0] mdat);
      bus.req_cyc_i = cyc;
      bus.req_stb_i = stb;
      bus.req_we_i  = we;
      bus.m_ack_i   = mack;
      bus.m_dat_i   = mdat;
   endtask

   // Global watchdog so the run can never hang
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          ng;
      logic [2:0]  prev_gnt;
      logic [2:0]  exp_oh;

      bus.io_gate_en_i = 1'b1;
      bus.m_stall_i    = 1'b0;
      bus.req_sel_i    = {4'b0100, 4'b0010, 4'b0001};
      bus.req_adr_i    = {32'hFD0C_0020, 32'hFD0C_0010, 32'hFD0C_0000};
      bus.req_dat_i    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);

      // Reset state
      #12;
      chk("rst_gnt",  32'(bus.gnt_o), 32'h0);
      chk("rst_mcyc", 32'(bus.m_cyc_o), 32'h0);
      chk("rst_ack",  32'(bus.req_ack_o), 32'h0);
      chk("rst_err",  32'(bus.req_err_o), 32'h0);
      chk("rst_rdat", bus.req_dat_o, 32'h0);
      chk("rst_adr",  bus.m_adr_o, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Single read, abort, gating/stall, late ack ignored, write latch
      vecs[0]  = mk(3'b010,3'b010,3'b000,1,0,0,32'h0,        3'b010,1,0,3'b000,32'hFD0C_0010,32'h0);
      vecs[1]  = mk(3'b010,3'b010,3'b000,1,0,0,32'h0,        3'b010,1,0,3'b000,32'hFD0C_0010,32'h0);
      vecs[2]  = mk(3'b010,3'b010,3'b000,1,0,0,32'h0,        3'b010,1,0,3'b000,32'hFD0C_0010,32'h0);
      vecs[3]  = mk(3'b010,3'b010,3'b000,1,0,1,32'hDEAD_BEEF,3'b010,0,0,3'b010,32'h0,32'hDEAD_BEEF);
      vecs[4]  = mk(3'b000,3'b000,3'b000,1,0,0,32'h0,        3'b000,0,0,3'b000,32'h0,32'h0);
      vecs[5]  = mk(3'b101,3'b101,3'b000,1,0,0,32'h0,        3'b100,1,0,3'b000,32'hFD0C_0020,32'h0);
      vecs[6]  = mk(3'b101,3'b101,3'b000,1,0,0,32'h0,        3'b100,1,0,3'b000,32'hFD0C_0020,32'h0);
      vecs[7]  = mk(3'b001,3'b001,3'b000,1,0,0,32'h0,        3'b000,0,0,3'b000,32'h0,32'h0);
      vecs[8]  = mk(3'b001,3'b001,3'b000,1,0,0,32'h0,        3'b001,1,0,3'b000,32'hFD0C_0000,32'h0);
      vecs[9]  = mk(3'b001,3'b001,3'b000,1,0,1,32'h1234_5678,3'b001,0,0,3'b001,32'h0,32'h1234_5678);
      vecs[10] = mk(3'b000,3'b000,3'b000,1,0,0,32'h0,        3'b000,0,0,3'b000,32'h0,32'h0);
      for (int i = 11; i <= 15; i++)
         vecs[i] = mk(3'b010,3'b010,3'b000,0,0,0,32'h0,      3'b000,0,0,3'b000,32'h0,32'h0);
      vecs[16] = mk(3'b010,3'b010,3'b000,1,1,0,32'h0,        3'b000,0,0,3'b000,32'h0,32'h0);
      vecs[17] = mk(3'b010,3'b010,3'b000,1,1,0,32'h0,        3'b000,0,0,3'b000,32'h0,32'h0);
      vecs[18] = mk(3'b010,3'b010,3'b000,1,0,0,32'h0,        3'b010,1,0,3'b000,32'hFD0C_0010,32'h0);
      vecs[19] = mk(3'b010,3'b010,3'b000,1,1,1,32'hCAFE_F00D,3'b010,0,0,3'b010,32'h0,32'hCAFE_F00D);
      vecs[20] = mk(3'b000,3'b000,3'b000,1,0,0,32'h0,        3'b000,0,0,3'b000,32'h0,32'h0);
      vecs[21] = mk(3'b100,3'b100,3'b100,1,0,1,32'h0,        3'b000,0,0,3'b000,32'h0,32'h0);
      vecs[22] = mk(3'b100,3'b100,3'b100,1,0,0,32'h0,        3'b100,1,1,3'b000,32'hFD0C_0020,32'h0);
      vecs[23] = mk(3'b100,3'b100,3'b100,1,0,1,32'h0000_0001,3'b100,0,0,3'b100,32'h0,32'h0000_0001);
      vecs[24] = mk(3'b000,3'b000,3'b000,1,0,0,32'h0,        3'b000,0,0,3'b000,32'h0,32'h0);

      for (int i = 0; i < 25; i++) begin
         drive(vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].mack, vecs[i].mdat);
         bus.io_gate_en_i = vecs[i].gate;
         bus.m_stall_i    = vecs[i].stall;
         tick();
         $display("vec %0d: gnt=%b m_cyc=%b ack=%b adr=%08h rdat=%08h", i,
                  bus.gnt_o, bus.m_cyc_o, bus.req_ack_o, bus.m_adr_o, bus.req_dat_o);
         chk($sformatf("v%0d_gnt", i),  32'(bus.gnt_o),     32'(vecs[i].e_gnt));
         chk($sformatf("v%0d_mcyc", i), 32'(bus.m_cyc_o),   32'(vecs[i].e_mcyc));
         chk($sformatf("v%0d_mstb", i), 32'(bus.m_stb_o),   32'(vecs[i].e_mcyc));
         chk($sformatf("v%0d_mwe", i),  32'(bus.m_we_o),    32'(vecs[i].e_we));
         chk($sformatf("v%0d_ack", i),  32'(bus.req_ack_o), 32'(vecs[i].e_ack));
         chk($sformatf("v%0d_err", i),  32'(bus.req_err_o), 32'h0);
         chk($sformatf("v%0d_adr", i),  bus.m_adr_o,        vecs[i].e_adr);
         chk($sformatf("v%0d_rdat", i), bus.req_dat_o,      vecs[i].e_rdat);
      end
      bus.io_gate_en_i = 1'b1;
      bus.m_stall_i    = 1'b0;

      // Contention: all three request continuously, expect 0,1,2,0,1,2
      ng       = 0;
      prev_gnt = 3'b000;
      drive(3'b111, 3'b111, 3'b000, 1'b0, 32'h0);
      for (int c = 0; c < 200; c++) begin
         tick();
         if (bus.gnt_o != 3'b000 && prev_gnt == 3'b000 && ng < 6) begin
            exp_oh = 3'b001 << (ng % 3);
            $display("contention grant %0d: gnt=%b", ng, bus.gnt_o);
            chk($sformatf("rr_grant%0d", ng), 32'(bus.gnt_o), 32'(exp_oh));
            ng++;
         end
         prev_gnt     = bus.gnt_o;
         bus.m_ack_i  = bus.m_cyc_o;
         bus.m_dat_i  = 32'h0;
         if (ng < 6) bus.req_cyc_i = ~bus.req_ack_o;
         else        bus.req_cyc_i = bus.gnt_o & ~bus.req_ack_o;
         bus.req_stb_i = bus.req_cyc_i;
         if (ng == 6 && bus.gnt_o == 3'b000 && !bus.m_cyc_o && bus.req_ack_o == 3'b000)
            break;
      end
      chk("rr_count", 32'(ng), 32'd6);
      chk("rr_idle_gnt", 32'(bus.gnt_o), 32'h0);
      drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);

      // RMW lock: requester 0 reads then writes under one cyc, 2 waits
      drive(3'b101, 3'b101, 3'b000, 1'b0, 32'h0);             tick();
      $display("rmw read issue: gnt=%b m_cyc=%b", bus.gnt_o, bus.m_cyc_o);
      chk("rmw_gnt_rd", 32'(bus.gnt_o), 32'h1);
      chk("rmw_mcyc_rd", 32'(bus.m_cyc_o), 32'h1);
      drive(3'b101, 3'b101, 3'b000, 1'b1, 32'h0000_0055);     tick();
      chk("rmw_ack_rd", 32'(bus.req_ack_o), 32'h1);
      chk("rmw_rdat", bus.req_dat_o, 32'h0000_0055);
      drive(3'b101, 3'b100, 3'b000, 1'b0, 32'h0);             tick();
      chk("rmw_lock_ack", 32'(bus.req_ack_o), 32'h0);
      chk("rmw_lock_gnt", 32'(bus.gnt_o), 32'h1);
      chk("rmw_lock_mcyc", 32'(bus.m_cyc_o), 32'h0);
      drive(3'b101, 3'b101, 3'b001, 1'b0, 32'h0);             tick();
      $display("rmw write issue: gnt=%b m_we=%b", bus.gnt_o, bus.m_we_o);
      chk("rmw_mcyc_wr", 32'(bus.m_cyc_o), 32'h1);
      chk("rmw_mwe_wr", 32'(bus.m_we_o), 32'h1);
      chk("rmw_gnt_wr", 32'(bus.gnt_o), 32'h1);
      chk("rmw_mdat_wr", bus.m_dat_o, 32'h1111_1111);
      drive(3'b101, 3'b101, 3'b001, 1'b1, 32'h0);             tick();
      chk("rmw_ack_wr", 32'(bus.req_ack_o), 32'h1);
      drive(3'b100, 3'b100, 3'b000, 1'b0, 32'h0);             tick();
      chk("rmw_release", 32'(bus.gnt_o), 32'h0);
      tick();
      $display("rmw waiter: gnt=%b", bus.gnt_o);
      chk("rmw_next_gnt", 32'(bus.gnt_o), 32'h4);
      drive(3'b100, 3'b100, 3'b000, 1'b1, 32'h0);             tick();
      chk("rmw_next_ack", 32'(bus.req_ack_o), 32'h4);
      drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);             tick();
      chk("rmw_end_gnt", 32'(bus.gnt_o), 32'h0);

`ifdef IOARB_TIMEOUT_EN
      // Timeout: no device ack, error pulses after the 8th WAIT_ACK cycle
      drive(3'b010, 3'b010, 3'b000, 1'b0, 32'h0);             tick();
      chk("to_gnt", 32'(bus.gnt_o), 32'h2);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("to_early%0d", k), 32'(bus.req_err_o), 32'h0);
      end
      tick();
      $display("timeout: err=%b m_cyc=%b gnt=%b", bus.req_err_o, bus.m_cyc_o, bus.gnt_o);
      chk("to_err", 32'(bus.req_err_o), 32'h2);
      chk("to_mcyc", 32'(bus.m_cyc_o), 32'h0);
      chk("to_gnt_clr", 32'(bus.gnt_o), 32'h0);
      drive(3'b000, 3'b000, 3'b000, 1'b1, 32'h0);             tick();
      chk("to_err_pulse", 32'(bus.req_err_o), 32'h0);
      chk("to_late_ack", 32'(bus.req_ack_o), 32'h0);
      drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);             tick();
`endif

      // Asynchronous reset in the middle of WAIT_ACK
      drive(3'b001, 3'b001, 3'b000, 1'b0, 32'h0);             tick();
      chk("ar_mcyc_before", 32'(bus.m_cyc_o), 32'h1);
      tick();
      #2;
      rst_i = 1'b1;
      #1;
      $display("async reset: gnt=%b m_cyc=%b ack=%b", bus.gnt_o, bus.m_cyc_o, bus.req_ack_o);
      chk("ar_gnt", 32'(bus.gnt_o), 32'h0);
      chk("ar_mcyc", 32'(bus.m_cyc_o), 32'h0);
      chk("ar_ack", 32'(bus.req_ack_o), 32'h0);
      chk("ar_adr", bus.m_adr_o, 32'h0);
      drive(3'b111, 3'b111, 3'b000, 1'b0, 32'h0);
      @(negedge clk_i);
      rst_i = 1'b0;
      tick();
      chk("ar_ptr_first", 32'(bus.gnt_o), 32'h1);
      drive(3'b000, 3'b000, 3'b000, 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
